// File: rtl/toggle_mon_pkg.sv
// toggle_mon_pkg: shared state encoding and default parameter values for the
// toggle_monitor block and its gap timer.
package toggle_mon_pkg;

  localparam int COUNT_W_DEF    = 16;
  localparam int INT_W_DEF      = 8;
  localparam int TIMEOUT_DEF    = 16;
  localparam int LOCK_EDGES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } tm_state_e;

endpackage

// File: rtl/toggle_mon_if.sv
// toggle_mon_if: crossed data bit and clear going into the monitor, and its
// debug readout (edge count, lock/fault flags, interval statistics) coming out.
interface toggle_mon_if
  import toggle_mon_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int INT_W   = INT_W_DEF
);
  logic               din;
  logic               clear;
  logic [COUNT_W-1:0] edge_count;
  logic               locked;
  logic               fault;
  logic [INT_W-1:0]   last_interval;
  logic [INT_W-1:0]   min_interval;
  logic [INT_W-1:0]   max_interval;

  // Stimulus / readout side.
  modport master (
    output din, clear,
    input  edge_count, locked, fault, last_interval, min_interval, max_interval
  );

  // Monitor side.
  modport slave (
    input  din, clear,
    output edge_count, locked, fault, last_interval, min_interval, max_interval
  );
endinterface

// File: rtl/tm_gap_timer.sv
// tm_gap_timer: counts cycles since the last transition, saturating at
// all-ones, and flags the TIMEOUT-th consecutive edgeless cycle.
module tm_gap_timer #(
  parameter int INT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             Bclk,
  input  logic             reset,
  input  logic             edge_det,
  input  logic             clear,
  output logic [INT_W-1:0] gap,
  output logic             timeout
);
  localparam logic [INT_W-1:0] GAP_MAX = '1;
  localparam logic [INT_W-1:0] GAP_TO  = INT_W'(TIMEOUT - 1);

  // Restart on every edge (or clear), otherwise count up and stick at max.
  always_ff @(posedge Bclk or posedge reset) begin
    if (reset) begin
      gap <= '0;
    end else if (clear || edge_det) begin
      gap <= '0;
    end else if (gap != GAP_MAX) begin
      gap <= gap + 1'b1;
    end
  end

  // gap reads TIMEOUT-1 on the TIMEOUT-th cycle without a transition.
  assign timeout = !edge_det && (gap == GAP_TO);
endmodule

// File: rtl/toggle_monitor.sv
// toggle_monitor: counts transitions of the crossed data bit and runs an
// IDLE/ACQ/TRACK/FAULT machine reporting regular toggling (locked) or a stall
// (sticky fault). Interval statistics are built only when
// TOGGLE_MON_INTERVAL_EN is defined; otherwise the interval ports read 0.
module toggle_monitor
  import toggle_mon_pkg::*;
#(
  parameter int COUNT_W    = COUNT_W_DEF,
  parameter int INT_W      = INT_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int LOCK_EDGES = LOCK_EDGES_DEF
) (
  input logic        Bclk,
  input logic        reset,
  toggle_mon_if.slave bus
);
  localparam int                GOOD_W    = $clog2(LOCK_EDGES + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_EDGES);

  logic               d_q;
  logic               edge_det;
  logic [INT_W-1:0]   gap;
  logic               timeout;
  tm_state_e          state;
  logic [GOOD_W-1:0]  good;
  logic [COUNT_W-1:0] edge_count_q;
  logic               locked_q;
  logic               fault_q;

  // Previous din; loads even during clear so a discarded edge is not seen twice.
  always_ff @(posedge Bclk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= bus.din;
  end

  // Either polarity of change counts as a transition.
  assign edge_det = bus.din ^ d_q;

  tm_gap_timer #(
    .INT_W   (INT_W),
    .TIMEOUT (TIMEOUT)
  ) u_gap (
    .Bclk     (Bclk),
    .reset    (reset),
    .edge_det (edge_det),
    .clear    (bus.clear),
    .gap      (gap),
    .timeout  (timeout)
  );

  // Free-running transition count, wraps naturally at 2^COUNT_W.
  always_ff @(posedge Bclk or posedge reset) begin
    if (reset)              edge_count_q <= '0;
    else if (bus.clear)     edge_count_q <= '0;
    else if (edge_det)      edge_count_q <= edge_count_q + 1'b1;
  end

  // Acquire/track/fault machine with locked/fault registered alongside state.
  always_ff @(posedge Bclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      good     <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (bus.clear) begin
      state    <= IDLE;
      good     <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_det) begin
            good <= GOOD_W'(1);
            if (LOCK_EDGES == 1) begin
              state    <= TRACK;
              locked_q <= 1'b1;
            end else begin
              state <= ACQ;
            end
          end
        end
        ACQ: begin
          if (edge_det) begin
            good <= good + 1'b1;
            if (good + 1'b1 == GOOD_LOCK) begin
              state    <= TRACK;
              locked_q <= 1'b1;
            end
          end else if (timeout) begin
            state <= IDLE;
            good  <= '0;
          end
        end
        TRACK: begin
          if (timeout) begin
            state    <= FAULT;
            locked_q <= 1'b0;
            fault_q  <= 1'b1;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state    <= IDLE;
          good     <= '0;
          locked_q <= 1'b0;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.edge_count = edge_count_q;
  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;

`ifdef TOGGLE_MON_INTERVAL_EN
  logic [INT_W-1:0] last_q;
  logic [INT_W-1:0] min_q;
  logic [INT_W-1:0] max_q;
  logic [INT_W-1:0] new_iv;
  logic             seen_q;

  // Spacing of the current edge from the previous one, saturating.
  assign new_iv = (gap == '1) ? gap : gap + 1'b1;

  // Interval stats; the first edge after reset/clear has no valid predecessor,
  // so it only arms the min/max tracking.
  always_ff @(posedge Bclk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else if (bus.clear) begin
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else if (edge_det) begin
      last_q <= new_iv;
      seen_q <= 1'b1;
      if (seen_q && (new_iv < min_q)) min_q <= new_iv;
      if (seen_q && (new_iv > max_q)) max_q <= new_iv;
    end
  end

  assign bus.last_interval = last_q;
  assign bus.min_interval  = min_q;
  assign bus.max_interval  = max_q;
`else
  // gap only feeds the interval statistics, which this build leaves out.
  logic gap_unused;
  assign gap_unused = ^gap;

  assign bus.last_interval = '0;
  assign bus.min_interval  = '0;
  assign bus.max_interval  = '0;
`endif
endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor: scoreboard bench for toggle_monitor (COUNT_W=4 so the
// counter wrap is reachable). Expected outputs are queued as stimulus is
// driven and compared on the falling edge after the DUT clocks them in.
module tb_toggle_monitor;
  import toggle_mon_pkg::*;

  localparam int CW = 4;
  localparam int IW = 8;
  localparam int TO = 16;
  localparam int LE = 4;

`ifdef TOGGLE_MON_INTERVAL_EN
  localparam logic [IW-1:0] MIN_RST = '1;
  localparam bit            IV_EN   = 1'b1;
`else
  localparam logic [IW-1:0] MIN_RST = '0;
  localparam bit            IV_EN   = 1'b0;
`endif

  logic Bclk = 1'b0;
  logic reset;
  always #5 Bclk = ~Bclk;

  toggle_mon_if #(.COUNT_W(CW), .INT_W(IW)) bus ();

  toggle_monitor #(
    .COUNT_W    (CW),
    .INT_W      (IW),
    .TIMEOUT    (TO),
    .LOCK_EDGES (LE)
  ) dut (
    .Bclk  (Bclk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [CW-1:0] cnt;
    bit            lk;
    bit            ft;
  } exp_t;

  typedef struct {
    logic [IW-1:0] last;
    logic [IW-1:0] mn;
    logic [IW-1:0] mx;
  } iv_t;

  exp_t exp_q[$];
  iv_t  iv_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_m  = 0;

  task automatic tick();
    @(posedge Bclk);
    @(negedge Bclk);
  endtask

  task automatic push(input bit lk, input bit ft);
    exp_t e;
    e.cnt = cnt_m[CW-1:0];
    e.lk  = lk;
    e.ft  = ft;
    exp_q.push_back(e);
  endtask

  task automatic toggle();
    bus.din = ~bus.din;
    cnt_m++;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; bus.din = 1'b0; bus.clear = 1'b0;
    #1;
    checks++;
    if (bus.edge_count !== '0 || bus.locked !== 1'b0 || bus.fault !== 1'b0 ||
        bus.last_interval !== '0 || bus.min_interval !== MIN_RST || bus.max_interval !== '0) begin
      errors++;
      $display("FAIL reset_values: cnt=%0d lk=%b ft=%b last=%0d min=%0d max=%0d required 0 0 0 0 %0d 0",
               bus.edge_count, bus.locked, bus.fault, bus.last_interval, bus.min_interval,
               bus.max_interval, MIN_RST);
    end
    @(negedge Bclk); @(negedge Bclk);
    reset = 1'b0;
    cnt_m = 0;
    push(0, 0); tick();
    e = exp_q.pop_front(); checks++;
    if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
      errors++;
      $display("FAIL reset_idle: cnt=%0d lk=%b ft=%b required %0d %b %b",
               bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
    end
  endtask

  task automatic test_lock();
    exp_t e;
    for (int n = 1; n <= 4; n++) begin
      for (int h = 0; h < ((n < 4) ? 2 : 1); h++) begin
        if (h == 0) toggle();
        push(n == 4, 0); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
          errors++;
          $display("FAIL lock[%0d.%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                   n, h, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int j = 1; j <= TO; j++) begin
      push(j < TO, j == TO); tick();
      e = exp_q.pop_front(); checks++;
      if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
        errors++;
        $display("FAIL stall[%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                 j, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) toggle();
      push(0, 1); tick();
      e = exp_q.pop_front(); checks++;
      if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                 k, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    bus.din   = ~bus.din;
    bus.clear = 1'b1;
    cnt_m     = 0;
    push(0, 0); tick();
    bus.clear = 1'b0;
    push(0, 0); tick();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front(); checks++;
      if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
        errors++;
        $display("FAIL clear[%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                 k, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
      end
      if (k == 0) begin
        // second sample was clocked before the first compare; keep order
      end
    end
  endtask

  task automatic test_acq_abort();
    exp_t e;
    for (int n = 1; n <= 2; n++) begin
      for (int h = 0; h <= ((n == 1) ? 1 : TO); h++) begin
        if (h == 0) toggle();
        push(0, 0); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
          errors++;
          $display("FAIL acq_abort[%0d.%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                   n, h, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
        end
      end
    end
    for (int n = 1; n <= 4; n++) begin
      for (int h = 0; h < ((n < 4) ? 2 : 1); h++) begin
        if (h == 0) toggle();
        push(n == 4, 0); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
          errors++;
          $display("FAIL relock[%0d.%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                   n, h, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    bus.clear = 1'b1;
    cnt_m     = 0;
    push(0, 0); tick();
    bus.clear = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
      errors++;
      $display("FAIL wrap_clear: cnt=%0d lk=%b ft=%b required %0d %b %b",
               bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
    end
    for (int n = 1; n <= 17; n++) begin
      for (int h = 0; h < 2; h++) begin
        if (h == 0) toggle();
        push(n >= LE, 0); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.edge_count !== e.cnt || bus.locked !== e.lk || bus.fault !== e.ft) begin
          errors++;
          $display("FAIL wrap[%0d.%0d]: cnt=%0d lk=%b ft=%b required %0d %b %b",
                   n, h, bus.edge_count, bus.locked, bus.fault, e.cnt, e.lk, e.ft);
        end
      end
    end
    checks++;
    if (bus.edge_count !== 4'd1 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL wrap_final: cnt=%0d lk=%b required 1 1", bus.edge_count, bus.locked);
    end
    // Mid-TRACK asynchronous reset, well clear of the next rising edge.
    #2 reset = 1'b1;
    bus.din = 1'b0;
    #1;
    checks++;
    if (bus.edge_count !== '0 || bus.locked !== 1'b0 || bus.fault !== 1'b0 ||
        bus.last_interval !== '0 || bus.min_interval !== MIN_RST || bus.max_interval !== '0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d lk=%b ft=%b last=%0d min=%0d max=%0d required 0 0 0 0 %0d 0",
               bus.edge_count, bus.locked, bus.fault, bus.last_interval, bus.min_interval,
               bus.max_interval, MIN_RST);
    end
    @(negedge Bclk);
    reset = 1'b0;
    cnt_m = 0;
  endtask

  task automatic test_intervals();
    int  spacing [4] = '{3, 3, 7, 2};
    iv_t tbl     [5];
    iv_t r;
    tbl[0] = '{IW'(1), '1, '0};
    tbl[1] = '{IW'(3), IW'(3), IW'(3)};
    tbl[2] = '{IW'(3), IW'(3), IW'(3)};
    tbl[3] = '{IW'(7), IW'(3), IW'(7)};
    tbl[4] = '{IW'(2), IW'(2), IW'(7)};
    for (int n = 0; n < 5; n++) begin
      if (n > 0) begin
        for (int h = 1; h < spacing[n-1]; h++) tick();
      end
      toggle();
      if (IV_EN) iv_q.push_back(tbl[n]);
      else       iv_q.push_back('{'0, '0, '0});
      tick();
      r = iv_q.pop_front(); checks++;
      if (bus.last_interval !== r.last || bus.min_interval !== r.mn || bus.max_interval !== r.mx) begin
        errors++;
        $display("FAIL interval[%0d]: last=%0d min=%0d max=%0d required %0d %0d %0d",
                 n, bus.last_interval, bus.min_interval, bus.max_interval, r.last, r.mn, r.mx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stall();
    test_clear();
    test_acq_abort();
    test_wrap_reset();
    test_intervals();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
